// File: rtl/uart_pkg.sv
// Shared definitions for the UART init sequencer: 16550-style register map,
// LSR/FCR constants and the sequencer state encoding.
package uart_pkg;

  localparam logic [7:0] ADDR_THR = 8'h00;
  localparam logic [7:0] ADDR_DLL = 8'h00;
  localparam logic [7:0] ADDR_DLM = 8'h01;
  localparam logic [7:0] ADDR_IER = 8'h01;
  localparam logic [7:0] ADDR_FCR = 8'h02;
  localparam logic [7:0] ADDR_LCR = 8'h03;
  localparam logic [7:0] ADDR_LSR = 8'h05;

  localparam int         LSR_THRE_BIT = 5;
  localparam logic [7:0] FCR_INIT     = 8'h07;
  localparam logic [7:0] LCR_DLAB     = 8'h80;
  localparam logic [2:0] CFG_LAST     = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_SETUP,
    ST_CFG_ACCESS,
    ST_READY,
    ST_POLL_SETUP,
    ST_POLL_ACCESS,
    ST_TX_SETUP,
    ST_TX_ACCESS,
    ST_ERROR
  } state_e;

  // Transmit-holding-register-empty flag out of a raw LSR read.
  function automatic logic lsr_thre(input logic [7:0] lsr);
    return lsr[LSR_THRE_BIT];
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB master phase engine. While req_i is high a transfer is in flight:
// the first cycle is SETUP, then ACCESS is held until pready_i. If req_i
// stays high on the completing cycle the next SETUP follows immediately.
// Ports: clk_i/rst_n_i; req_i/write_i/addr_i/wdata_i from the sequencer;
// done_o/rdata_o back to it; m_apb_* bus signals to the UART slave.
module apb_master_if (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic       write_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       m_apb_psel_o,
  output logic       m_apb_penable_o,
  output logic       m_apb_pwrite_o,
  output logic [7:0] m_apb_paddr_o,
  output logic [7:0] m_apb_pwdata_o,
  input  logic [7:0] m_apb_prdata_i,
  input  logic       m_apb_pready_i
);

  logic access_q, access_d;

  always_comb begin
    access_d = access_q;
    if (!req_i)              access_d = 1'b0;
    else if (!access_q)      access_d = 1'b1;
    else if (m_apb_pready_i) access_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) access_q <= 1'b0;
    else          access_q <= access_d;
  end

  // Bus outputs are gated by req_i so they read zero whenever no transfer runs.
  assign m_apb_psel_o    = req_i;
  assign m_apb_penable_o = req_i & access_q;
  assign m_apb_pwrite_o  = req_i & write_i;
  assign m_apb_paddr_o   = req_i ? addr_i  : 8'h00;
  assign m_apb_pwdata_o  = req_i ? wdata_i : 8'h00;
  assign done_o          = req_i & access_q & m_apb_pready_i;
  assign rdata_o         = m_apb_prdata_i;

endmodule

// File: rtl/uart_init_sequencer.sv
// Programs a 16550-style UART over APB (LCR/DLAB, divisor, LCR, FCR), then
// forwards bytes to THR after polling LSR.THRE, giving up after POLL_MAX
// consecutive not-empty reads.
// Ports: clk_i/rst_n_i; start_i plus config inputs; tx_valid_i/tx_data_i/
// tx_ready_o byte handshake; cfg_done_o/busy_o/err_o status; m_apb_* master.
//
// state      | meaning
// IDLE       | after reset, waiting for start_i
// CFG_SETUP  | SETUP phase of config write step_q
// CFG_ACCESS | ACCESS phase of config write step_q
// READY      | configured, waiting for tx_valid_i or start_i
// POLL_SETUP | SETUP phase of LSR read
// POLL_ACCESS| ACCESS phase of LSR read
// TX_SETUP   | SETUP phase of THR write
// TX_ACCESS  | ACCESS phase of THR write
// ERROR      | poll limit hit, waiting for start_i
module uart_init_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] baud_div_i,
  input  logic [1:0]  word_len_i,
  input  logic        stp_bits_i,
  input  logic        parity_en_i,
  input  logic        even_parity_sel_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        m_apb_psel_o,
  output logic        m_apb_penable_o,
  output logic        m_apb_pwrite_o,
  output logic [7:0]  m_apb_paddr_o,
  output logic [7:0]  m_apb_pwdata_o,
  input  logic [7:0]  m_apb_prdata_i,
  input  logic        m_apb_pready_i
);

  localparam logic [8:0] POLL_LIMIT = 9'(POLL_MAX);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [4:0]  lcr_q, lcr_d;
  logic        cfg_done_q, cfg_done_d;
  logic        err_q, err_d;

  logic        apb_req, apb_write, apb_done;
  logic [7:0]  apb_addr, apb_wdata, apb_rdata;
  logic [8:0]  poll_nxt;

  assign poll_nxt = {1'b0, poll_cnt_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    baud_d     = baud_q;
    lcr_d      = lcr_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE, ST_READY, ST_ERROR: begin
        // start_i beats tx_valid_i when both arrive in READY.
        if (start_i) begin
          baud_d     = baud_div_i;
          lcr_d      = {even_parity_sel_i, parity_en_i, stp_bits_i, word_len_i};
          step_d     = 3'd0;
          cfg_done_d = 1'b0;
          err_d      = 1'b0;
          state_d    = ST_CFG_SETUP;
        end else if (state_q == ST_READY && tx_valid_i) begin
          poll_cnt_d = 8'd0;
          state_d    = ST_POLL_SETUP;
        end
      end
      ST_CFG_SETUP: state_d = ST_CFG_ACCESS;
      ST_CFG_ACCESS: begin
        if (apb_done) begin
          if (step_q == CFG_LAST) begin
            cfg_done_d = 1'b1;
            state_d    = ST_READY;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_CFG_SETUP;
          end
        end
      end
      ST_POLL_SETUP: state_d = ST_POLL_ACCESS;
      ST_POLL_ACCESS: begin
        if (apb_done) begin
          if (lsr_thre(apb_rdata)) begin
            state_d = ST_TX_SETUP;
          end else if (poll_nxt >= POLL_LIMIT) begin
            err_d      = 1'b1;
            cfg_done_d = 1'b0;
            state_d    = ST_ERROR;
          end else begin
            poll_cnt_d = poll_nxt[7:0];
            state_d    = ST_POLL_SETUP;
          end
        end
      end
      ST_TX_SETUP:  state_d = ST_TX_ACCESS;
      ST_TX_ACCESS: if (apb_done) state_d = ST_READY;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Transfer descriptor for the current state; constant across SETUP/ACCESS.
  always_comb begin
    apb_req   = 1'b0;
    apb_write = 1'b0;
    apb_addr  = 8'h00;
    apb_wdata = 8'h00;
    case (state_q)
      ST_CFG_SETUP, ST_CFG_ACCESS: begin
        apb_req   = 1'b1;
        apb_write = 1'b1;
        case (step_q)
          3'd0: begin apb_addr = ADDR_LCR; apb_wdata = LCR_DLAB | {3'b000, lcr_q}; end
          3'd1: begin apb_addr = ADDR_DLL; apb_wdata = baud_q[7:0]; end
          3'd2: begin apb_addr = ADDR_DLM; apb_wdata = baud_q[15:8]; end
          3'd3: begin apb_addr = ADDR_LCR; apb_wdata = {3'b000, lcr_q}; end
          default: begin apb_addr = ADDR_FCR; apb_wdata = FCR_INIT; end
        endcase
      end
      ST_POLL_SETUP, ST_POLL_ACCESS: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_LSR;
      end
      ST_TX_SETUP, ST_TX_ACCESS: begin
        apb_req   = 1'b1;
        apb_write = 1'b1;
        apb_addr  = ADDR_THR;
        apb_wdata = tx_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      poll_cnt_q <= 8'd0;
      baud_q     <= 16'd0;
      lcr_q      <= 5'd0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      baud_q     <= baud_d;
      lcr_q      <= lcr_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
    end
  end

  apb_master_if u_apb (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .req_i           (apb_req),
    .write_i         (apb_write),
    .addr_i          (apb_addr),
    .wdata_i         (apb_wdata),
    .done_o          (apb_done),
    .rdata_o         (apb_rdata),
    .m_apb_psel_o    (m_apb_psel_o),
    .m_apb_penable_o (m_apb_penable_o),
    .m_apb_pwrite_o  (m_apb_pwrite_o),
    .m_apb_paddr_o   (m_apb_paddr_o),
    .m_apb_pwdata_o  (m_apb_pwdata_o),
    .m_apb_prdata_i  (m_apb_prdata_i),
    .m_apb_pready_i  (m_apb_pready_i)
  );

  assign tx_ready_o = (state_q == ST_TX_ACCESS) && apb_done;
  assign busy_o     = !(state_q == ST_IDLE || state_q == ST_READY || state_q == ST_ERROR);
  assign cfg_done_o = cfg_done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_init_sequencer.sv
// Bench for uart_init_sequencer: APB slave model with programmable wait
// states and LSR responses, expected-transfer queue checked by a monitor.
module tb_uart_init_sequencer;

  localparam int POLL_MAX = 4;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] baud = 16'h0;
  logic [1:0]  wlen = 2'd0;
  logic        stp = 1'b0, par = 1'b0, even = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, cfg_done, busy, err;
  logic        psel, penable, pwrite, pready;
  logic [7:0]  paddr, pwdata, prdata;

  int total = 0;
  int bad = 0;
  xfer_t exp_q[$];
  xfer_t e_m;

  always #5 clk = ~clk;

  uart_init_sequencer #(.POLL_MAX(POLL_MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .baud_div_i(baud),
    .word_len_i(wlen), .stp_bits_i(stp), .parity_en_i(par), .even_parity_sel_i(even),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
    .cfg_done_o(cfg_done), .busy_o(busy), .err_o(err),
    .m_apb_psel_o(psel), .m_apb_penable_o(penable), .m_apb_pwrite_o(pwrite),
    .m_apb_paddr_o(paddr), .m_apb_pwdata_o(pwdata),
    .m_apb_prdata_i(prdata), .m_apb_pready_i(pready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int         waits = 0;
  int         wcnt;
  int         rd_count = 0;
  int         rd_base = 0;
  int         ri_w;
  logic [7:0] lsr_seq [8];
  int         lsr_len = 0;
  logic [7:0] lsr_tail = 8'h00;

  assign pready = psel & penable & (wcnt == waits);
  assign ri_w   = rd_count - rd_base;
  assign prdata = (ri_w < lsr_len) ? lsr_seq[ri_w[2:0]] : lsr_tail;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (psel && penable) begin
      wcnt <= pready ? 0 : wcnt + 1;
      if (pready && !pwrite) rd_count <= rd_count + 1;
    end
  end

  // ---------------- monitor ----------------
  int         acc_cyc = 0;
  int         txr_cnt = 0;
  logic [7:0] s_addr = 8'h00, s_data = 8'h00;
  logic       s_wr = 1'b0;
  logic       stable = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cyc = 0;
      stable  = 1'b1;
    end else begin
      if (tx_ready) txr_cnt++;
      if (psel && !penable) begin
        s_addr = paddr; s_data = pwdata; s_wr = pwrite; stable = 1'b1;
      end
      if (psel && penable) begin
        acc_cyc++;
        if (paddr !== s_addr || pwdata !== s_data || pwrite !== s_wr) stable = 1'b0;
        if (pready) begin
          chk("xfer_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e_m = exp_q.pop_front();
            chk("pwrite", pwrite, e_m.wr);
            chk("paddr", paddr, e_m.addr);
            if (e_m.wr) chk("pwdata", pwdata, e_m.data);
          end
          chk("access_len", acc_cyc, waits + 1);
          chk("addr_data_stable", stable, 1);
          acc_cyc = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_cfg_0145();
    push(1, 8'h03, 8'h83); push(1, 8'h00, 8'h45); push(1, 8'h01, 8'h01);
    push(1, 8'h03, 8'h03); push(1, 8'h02, 8'h07);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_psel"}, psel, 0);       chk({nm, "_penable"}, penable, 0);
    chk({nm, "_pwrite"}, pwrite, 0);   chk({nm, "_paddr"}, paddr, 0);
    chk({nm, "_pwdata"}, pwdata, 0);   chk({nm, "_tx_ready"}, tx_ready, 0);
    chk({nm, "_cfg_done"}, cfg_done, 0); chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  // cfg cycles are counted from the edge that samples start_i.
  task automatic run_cfg(input int exp_cyc, input bit with_tx, input string nm);
    int cyc;
    @(posedge clk); #1 start = 1'b1; if (with_tx) begin tx_valid = 1'b1; tx_data = 8'hEE; end
    @(posedge clk); #1 start = 1'b0; tx_valid = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_done_clr"}, cfg_done, 0);
    chk({nm, "_err_clr"}, err, 0);
    cyc = 0;
    while (!cfg_done && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk({nm, "_cfg_cycles"}, cyc, exp_cyc);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_tx(input logic [7:0] d, input int exp_reads, input bit exp_ok, input string nm);
    int cyc;
    int t0;
    rd_base = rd_count;
    t0 = txr_cnt;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = d;
    cyc = 0;
    while (!tx_ready && !err && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk({nm, "_timeout"}, cyc < 300, 1);
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk({nm, "_reads"}, rd_count - rd_base, exp_reads);
    chk({nm, "_tx_ready_pulses"}, txr_cnt - t0, exp_ok ? 1 : 0);
    chk({nm, "_err"}, err, !exp_ok);
    chk({nm, "_cfg_done"}, cfg_done, exp_ok);
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int t0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // zero-wait config
    waits = 0; baud = 16'h0145; wlen = 2'd3;
    push_cfg_0145();
    run_cfg(10, 0, "cfg0");

    // 3 wait states per access: 5 x (1 + 4) cycles
    waits = 3;
    push_cfg_0145();
    run_cfg(25, 0, "cfg3w");

    // all LCR fields set: lcr = 1_1_1_10 = 0x1E
    waits = 1; baud = 16'hBEEF; wlen = 2'd2; stp = 1'b1; par = 1'b1; even = 1'b1;
    push(1, 8'h03, 8'h9E); push(1, 8'h00, 8'hEF); push(1, 8'h01, 8'hBE);
    push(1, 8'h03, 8'h1E); push(1, 8'h02, 8'h07);
    run_cfg(15, 0, "cfg_lcr");

    // TX after two busy polls
    waits = 0;
    lsr_seq[0] = 8'h00; lsr_seq[1] = 8'h00; lsr_seq[2] = 8'h60; lsr_len = 3; lsr_tail = 8'h20;
    push(0, 8'h05, 8'h00); push(0, 8'h05, 8'h00); push(0, 8'h05, 8'h00); push(1, 8'h00, 8'hA5);
    run_tx(8'hA5, 3, 1, "tx_a5");

    // THRE appears on the last allowed read
    waits = 2;
    lsr_seq[0] = 8'h00; lsr_seq[1] = 8'h00; lsr_seq[2] = 8'h00; lsr_seq[3] = 8'h20; lsr_len = 4;
    push(0, 8'h05, 8'h00); push(0, 8'h05, 8'h00); push(0, 8'h05, 8'h00); push(0, 8'h05, 8'h00);
    push(1, 8'h00, 8'h3C);
    run_tx(8'h3C, 4, 1, "tx_edge");

    // poll limit exhausted
    waits = 0; lsr_len = 0; lsr_tail = 8'h00;
    repeat (POLL_MAX) push(0, 8'h05, 8'h00);
    run_tx(8'h5A, POLL_MAX, 0, "poll_err");
    t0 = txr_cnt;
    tx_valid = 1'b1; tx_data = 8'h11;
    repeat (5) @(posedge clk); #1;
    chk("err_hold_psel", psel, 0);
    chk("err_hold_busy", busy, 0);
    chk("err_hold_err", err, 1);
    tx_valid = 1'b0;
    baud = 16'h0145; wlen = 2'd3; stp = 1'b0; par = 1'b0; even = 1'b0;
    push_cfg_0145();
    run_cfg(10, 0, "err_restart");
    chk("err_no_tx", txr_cnt - t0, 0);

    // reset during CFG_ACCESS of index 2
    waits = 3;
    push_cfg_0145();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(psel && penable && paddr == 8'h01) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("rst_reach_idx2", cyc < 100, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    exp_q.delete();
    @(posedge clk); #1;
    chk_zero("rst_held");
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_no_resume", busy, 0);
    waits = 0;
    push_cfg_0145();
    run_cfg(10, 0, "rst_restart");

    // start_i and tx_valid_i together in READY
    t0 = txr_cnt;
    push_cfg_0145();
    run_cfg(10, 1, "start_tx_tie");
    repeat (3) @(posedge clk); #1;
    chk("tie_no_tx", txr_cnt - t0, 0);
    chk("tie_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_init_sequencer.md
UART_INIT_SEQUENCER -- requirements
Module: uart_init_sequencer

Interface
REQ-001 Parameter POLL_MAX, default 255: maximum consecutive LSR reads per TX byte before error.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 start_i  input  1  one-cycle pulse; latches config, begins programming sequence.
REQ-005 baud_div_i  input  16  divisor for DLL/DLM.
REQ-006 word_len_i  input  2  LCR[1:0]; stp_bits_i  input  1  LCR[2]; parity_en_i  input  1  LCR[3]; even_parity_sel_i  input  1  LCR[4].
REQ-007 tx_valid_i  input  1  / tx_data_i  input  8  / tx_ready_o  output  1  byte-send valid/ready handshake.
REQ-008 cfg_done_o  output  1  programming complete, TX path open; busy_o  output  1  FSM not in IDLE/READY/ERROR; err_o  output  1  poll limit hit.
REQ-009 m_apb_psel_o, m_apb_penable_o, m_apb_pwrite_o  output  1 each; m_apb_paddr_o  output  8; m_apb_pwdata_o  output  8  APB master to UART controller slave port.
REQ-010 m_apb_prdata_i  input  8; m_apb_pready_i  input  1  APB master return path.

Function
REQ-011 FSM states: IDLE, CFG_SETUP, CFG_ACCESS, READY, POLL_SETUP, POLL_ACCESS, TX_SETUP, TX_ACCESS, ERROR.
REQ-012 SETUP: psel=1, penable=0, one cycle; ACCESS: psel=1, penable=1, held until pready_i=1; addr/wdata/pwrite stable across SETUP and ACCESS.
REQ-013 Next transfer's SETUP directly follows the completing ACCESS cycle; no idle cycle inserted.
REQ-014 start_i in IDLE, READY or ERROR latches all config inputs, clears err_o and cfg_done_o, and enters CFG_SETUP with step index 0; start_i is ignored in every other state.
REQ-015 Config writes in order, index 0..4: addr 0x03 data {1,0,0,even,par,stp,wlen}; 0x00 baud[7:0]; 0x01 baud[15:8]; 0x03 {0,0,0,even,par,stp,wlen}; 0x02 data 0x07.
REQ-016 After index 4 completes: cfg_done_o=1 and the FSM enters READY; an ideal slave gives 10 cycles start_i-to-cfg_done_o.
REQ-017 READY with tx_valid_i=1: read LSR (addr 0x05, pwrite=0); sample prdata at the completing ACCESS cycle.
REQ-018 LSR[5]=1: go to TX_SETUP and write tx_data_i to addr 0x00; tx_ready_o is a one-cycle pulse in the completing TX_ACCESS cycle, then the FSM returns to READY.
REQ-019 LSR[5]=0: increment the 8-bit poll counter and re-read; the counter clears on each new byte; reaching POLL_MAX failed reads sets err_o=1 and enters ERROR, with no THR write and no tx_ready_o.
REQ-020 tx_valid_i/tx_data_i are held stable by the requester until tx_ready_o; tx_valid_i outside READY does not start a transfer.
REQ-021 start_i and tx_valid_i together in READY: start_i wins, no TX.
REQ-022 ERROR holds psel=0 and waits for start_i; cfg_done_o=0 in ERROR.
REQ-023 pready_i held low stalls indefinitely in ACCESS; no timeout.

Reset
REQ-024 rst_n_i low asynchronously forces IDLE and all outputs to 0: psel, penable, pwrite, paddr=0x00, pwdata=0x00, tx_ready, cfg_done, busy, err.
REQ-025 Reset mid-transfer abandons the APB access immediately; no sequence resume after reset release.

Structure
REQ-026 Shared package uart_pkg holds: register address constants (THR/DLL=0x00, DLM/IER=0x01, FCR=0x02, LCR=0x03, LSR=0x05), LSR_THRE_BIT=5, FCR_INIT=0x07, the FSM state enum.
REQ-027 One sub-module apb_master_if implements the SETUP/ACCESS handshake with req/done/rdata to the sequencer FSM.

Verification
REQ-028 baud_div_i=0x0145, word_len_i=3, others 0, start_i, zero-wait slave -> writes (03,83),(00,45),(01,01),(03,03),(02,07); cfg_done_o 10 cycles after start_i.
REQ-029 Same config, slave inserts 3 wait states per access -> identical write sequence; each ACCESS lasts 4 cycles; addr/wdata stable throughout.
REQ-030 After config, tx_valid_i=1, tx_data_i=0xA5, LSR returns 0x00 twice then 0x60 -> 3 reads at 0x05, 1 write (00,A5), one tx_ready_o pulse.
REQ-031 POLL_MAX=4, LSR always 0x00 -> exactly 4 reads, err_o=1, no THR write; start_i then clears err_o and reprograms.
REQ-032 rst_n_i asserted during CFG_ACCESS index 2 -> psel/penable drop the same cycle, all outputs 0; after release, start_i restarts at index 0.
REQ-033 start_i and tx_valid_i asserted together in READY -> config sequence runs, no LSR read, tx_ready_o stays 0.
